// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//
// Runs the PLL bring-up sequence. The PLL is held in reset for a fixed
// time. The supervisor then waits for lock and requires lock to stay high
// for a qualification window. After that it releases the downstream domain
// resets one after another, with a fixed gap between them. A failed lock
// attempt, or loss of lock after the domains have started to release,
// starts a new PLL reset. The supervisor latches a fault after too many
// failed attempts.
//
// Ports
//   clock           free-running reference clock (the only clock)
//   reset_n         asynchronous active-low reset
//   pll_locked      PLL lock indication, asynchronous to clock
//   pll_resetb      active-low reset to the PLL RESETB pin
//   domain_reset_n  active-low downstream resets, bit 0 released first
//   ready           high only while all domains run on a locked PLL
//   fault           sticky lock-failure flag, cleared only by reset_n
//   retry_count     failed lock attempts since reset (saturates at 15)
//
// Every output comes straight from a flop. The flops load from the
// next-state decode, so each output changes on the same edge as the state.

module pll_lock_supervisor #(
  parameter int PLL_RESET_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 4096,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int NUM_DOMAINS         = 2,
  parameter int STAGGER_CYCLES      = 8,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   pll_locked,
  output logic                   pll_resetb,
  output logic [NUM_DOMAINS-1:0] domain_reset_n,
  output logic                   ready,
  output logic                   fault,
  output logic [3:0]             retry_count
);

  // The shared counter must reach the largest limit in use. That includes
  // the release span, which is the offset of the last domain bit.
  localparam int REL_LAST  = (NUM_DOMAINS - 1) * STAGGER_CYCLES;
  localparam int MAX_AB    = (PLL_RESET_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RESET_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_ABC   = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int MAX_COUNT = (MAX_ABC > REL_LAST) ? MAX_ABC : REL_LAST;
  localparam int CNT_W     = $clog2(MAX_COUNT + 1);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_END  = CNT_W'(REL_LAST);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RELEASE,
    ST_RUN,
    ST_FAULT
  } state_t;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [3:0]             retry_reg, retry_next, retry_sat;
  logic                   retry_evt;
  logic                   sync1_reg, lock_s_reg;
  logic                   pll_resetb_reg, pll_resetb_next;
  logic                   ready_reg, ready_next;
  logic                   fault_reg, fault_next;
  logic [NUM_DOMAINS-1:0] domain_reg, domain_next;

  // Two-flop synchroniser for the asynchronous lock input.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg  <= 1'b0;
      lock_s_reg <= 1'b0;
    end else begin
      sync1_reg  <= pll_locked;
      lock_s_reg <= sync1_reg;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_PLL_RST;
      cnt_reg        <= '0;
      retry_reg      <= 4'd0;
      pll_resetb_reg <= 1'b0;
      ready_reg      <= 1'b0;
      fault_reg      <= 1'b0;
      domain_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      retry_reg      <= retry_next;
      pll_resetb_reg <= pll_resetb_next;
      ready_reg      <= ready_next;
      fault_reg      <= fault_next;
      domain_reg     <= domain_next;
    end
  end

  assign retry_sat = (retry_reg == 4'd15) ? 4'd15 : retry_reg + 4'd1;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    retry_next = retry_reg;
    retry_evt  = 1'b0;

    case (state_reg)
      ST_PLL_RST: begin
        if (cnt_reg == RST_LAST) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        // Lock is tested before the timeout, so lock wins if both happen
        // on the same cycle.
        if (lock_s_reg) begin
          state_next = ST_STABLE;
          cnt_next   = '0;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          retry_evt = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_STABLE: begin
        // A dropout during qualification is not a failed attempt. The
        // supervisor goes back to waiting for lock with a fresh timeout.
        if (!lock_s_reg) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == STABLE_LAST) begin
          state_next = ST_RELEASE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        // The counter holds the number of cycles since RELEASE was entered.
        // The domain mask below is decoded from it.
        if (!lock_s_reg) begin
          retry_evt = 1'b1;
        end else if (cnt_reg == RELEASE_END) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s_reg) begin
          retry_evt = 1'b1;
        end
      end
      ST_FAULT: begin
        state_next = ST_FAULT;
      end
      default: begin
        state_next = ST_PLL_RST;
        cnt_next   = '0;
      end
    endcase

    if (retry_evt) begin
      retry_next = retry_sat;
      cnt_next   = '0;
      state_next = (retry_sat == RETRY_LIMIT) ? ST_FAULT : ST_PLL_RST;
    end

    pll_resetb_next = (state_next == ST_WAIT_LOCK) || (state_next == ST_STABLE) ||
                      (state_next == ST_RELEASE)   || (state_next == ST_RUN);
    ready_next      = (state_next == ST_RUN);
    fault_next      = (state_next == ST_FAULT);
  end

  // Bit gi releases once the release counter reaches gi*STAGGER_CYCLES.
  // The counter only moves up inside RELEASE, so the bits cannot release
  // out of order. Leaving RELEASE/RUN for any state clears every bit.
  generate
    for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_domain
      if (gi == 0) begin : g_first
        assign domain_next[gi] = (state_next == ST_RUN) || (state_next == ST_RELEASE);
      end else begin : g_rest
        localparam logic [CNT_W-1:0] THRESH = CNT_W'(gi * STAGGER_CYCLES);
        assign domain_next[gi] = (state_next == ST_RUN) ||
                                 ((state_next == ST_RELEASE) && (cnt_next >= THRESH));
      end
    end
  endgenerate

  assign pll_resetb     = pll_resetb_reg;
  assign domain_reset_n = domain_reg;
  assign ready          = ready_reg;
  assign fault          = fault_reg;
  assign retry_count    = retry_reg;

endmodule
